// File: rtl/font_pkg.sv
// Shared constants and types for the font glyph sequencer.
// Geometry of the 6x8 font ROM and the glyph FSM encoding.
package font_pkg;

    localparam int          GLYPH_W    = 6;
    localparam logic [7:0]  FIRST_CHAR = 8'h20;
    localparam int          NUM_GLYPHS = 96;
    localparam int          BAD_GLYPH  = 31;
    localparam int          ADDR_W     = 10;

    localparam int IDX_W = $clog2(NUM_GLYPHS);
    // One extra count so the optional spacer column is representable
    localparam int COL_W = $clog2(GLYPH_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPT,
        OUT
    } state_t;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/font_addr_gen.sv
// Character-to-glyph mapping and ROM column address arithmetic.
// start selects the freshly mapped glyph at column 0, else idx at col.
module font_addr_gen
    import font_pkg::*;
(
    input  logic [7:0]        ch,
    input  logic              start,
    input  idx_t              idx,
    input  col_t              col,
    output idx_t              map_idx,
    output logic [ADDR_W-1:0] addr
);

    logic [8:0] code;
    logic [8:0] lo;
    logic [8:0] hi;
    logic       in_range;
    idx_t       idx_eff;
    col_t       col_eff;

    // Nine bits so FIRST_CHAR+NUM_GLYPHS cannot overflow
    assign code     = {1'b0, ch};
    assign lo       = 9'(FIRST_CHAR);
    assign hi       = lo + 9'(NUM_GLYPHS);
    assign in_range = (code >= lo) && (code < hi);
    assign map_idx  = in_range ? IDX_W'(code - lo) : IDX_W'(BAD_GLYPH);

    assign idx_eff = start ? map_idx : idx;
    assign col_eff = start ? '0 : col;

    assign addr = ADDR_W'(idx_eff) * ADDR_W'(GLYPH_W) + ADDR_W'(col_eff);

endmodule

// File: rtl/font_glyph_seq.sv
// Font ROM column sequencer: one char in, GLYPH_W column bytes out.
// Define FONT_SPACING_EN to append a blank 8'h00 spacer column per glyph.
module font_glyph_seq
    import font_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy
);

`ifdef FONT_SPACING_EN
    localparam int LAST_ROM_COL = GLYPH_W - 1;
    localparam bit SPACER       = 1'b1;
`else
    localparam int LAST_ROM_COL = GLYPH_W - 1;
    localparam bit SPACER       = 1'b0;
`endif

    state_t            state, state_n;
    col_t              col, col_n;
    idx_t              idx, idx_n;
    idx_t              map_idx;
    col_t              col_inc;
    logic [ADDR_W-1:0] addr_calc;
    logic              rom_rd_n;
    logic [ADDR_W-1:0] rom_addr_n;
    logic              out_valid_n;
    logic              out_last_n;
    logic [7:0]        out_data_n;
    logic              accept;
    logic              rom_col_end;

    assign in_ready    = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign accept      = in_valid && in_ready;
    assign col_inc     = col + col_t'(1);
    assign rom_col_end = (col == col_t'(LAST_ROM_COL));

    font_addr_gen u_addr (
        .ch      (in_char),
        .start   (state == IDLE),
        .idx     (idx),
        .col     (col_inc),
        .map_idx (map_idx),
        .addr    (addr_calc)
    );

    always_comb begin
        state_n     = state;
        col_n       = col;
        idx_n       = idx;
        rom_rd_n    = 1'b0;
        rom_addr_n  = rom_addr;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        out_data_n  = out_data;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    idx_n      = map_idx;
                    col_n      = '0;
                    rom_rd_n   = 1'b1;
                    rom_addr_n = addr_calc;
                    state_n    = READ;
                end
            end
            READ: begin
                state_n = CAPT;
            end
            CAPT: begin
                out_data_n  = rom_data;
                out_valid_n = 1'b1;
                out_last_n  = rom_col_end && !SPACER;
                state_n     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (out_last) begin
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        state_n     = IDLE;
                    end else if (SPACER && rom_col_end) begin
                        // Spacer byte needs no ROM read; stay in OUT
                        col_n      = col_inc;
                        out_data_n = 8'h00;
                        out_last_n = 1'b1;
                    end else begin
                        col_n       = col_inc;
                        out_valid_n = 1'b0;
                        rom_rd_n    = 1'b1;
                        rom_addr_n  = addr_calc;
                        state_n     = READ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            idx       <= '0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            idx       <= idx_n;
            rom_rd    <= rom_rd_n;
            rom_addr  <= rom_addr_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
        end
    end

endmodule

// File: tb/tb_font_glyph_seq.sv
// Self-checking bench for font_glyph_seq with a behavioural ROM and
// a reference model of glyph index, address and byte stream.
module tb_font_glyph_seq;

    localparam int GW   = 6;
`ifdef FONT_SPACING_EN
    localparam int NB   = GW + 1;
`else
    localparam int NB   = GW;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       rom_rd;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    logic [7:0] rom [1024];

    int checks = 0;
    int errors = 0;

    font_glyph_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Registered-output ROM with read enable
    initial rom_data = 8'h00;
    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_idx(input int ch);
        if (ch >= 32 && ch < 32 + 96) return ch - 32;
        return 31;
    endfunction

    function automatic logic [7:0] exp_byte(input int base, input int b);
        if (b >= GW) return 8'h00;
        return rom[base + b];
    endfunction

    // Starts at a negedge, returns at the negedge after the last handshake
    task automatic glyph(input logic [7:0] ch, input int stall_b,
                         input int stall_n, input bit hold,
                         input logic [7:0] nxt, input bit immediate);
        int  base, b, reads, st, cyc;
        bit  seen;
        base  = model_idx(int'(ch)) * GW;
        b     = 0;
        reads = 0;
        st    = 0;
        seen  = 1'b0;
        if (!immediate)
            for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_char   = ch;
        out_ready = 1'b1;
        @(negedge clk);
        if (hold) in_char = nxt;
        else begin
            in_valid = 1'b0;
            in_char  = 8'($urandom);
        end
        for (cyc = 1; cyc < 300 && b < NB; cyc++) begin
            chk("in_ready_busy", in_ready, 0);
            if (rom_rd) begin
                chk("rom_addr", rom_addr, base + reads);
                reads++;
            end
            if (out_valid) begin
                if (!seen) begin
                    chk("latency", cyc, 3);
                    seen = 1'b1;
                end
                chk("out_data", out_data, exp_byte(base, b));
                chk("out_last", out_last, (b == NB - 1));
                if (b == stall_b && st < stall_n) begin
                    out_ready = 1'b0;
                    st++;
                end else begin
                    out_ready = 1'b1;
                    b++;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        if (b < NB) chk("timeout", b, NB);
        chk("rd_count", reads, GW);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("valid_clr", out_valid, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        int  r;
        bit  quiet;
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rom_rd", rom_rd, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        glyph(8'h41, -1, 0, 1'b0, 8'h00, 1'b0);
        glyph(8'h10, -1, 0, 1'b0, 8'h00, 1'b0);
        glyph(8'h80, -1, 0, 1'b0, 8'h00, 1'b0);
        glyph(8'h20, 2, 5, 1'b0, 8'h00, 1'b0);
        glyph(8'h30, -1, 0, 1'b1, 8'h31, 1'b0);
        glyph(8'h31, -1, 0, 1'b0, 8'h00, 1'b1);

        // Abort a glyph with reset during CAPT of column 3
        in_valid  = 1'b1;
        in_char   = 8'h45;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        r = 0;
        for (int i = 0; i < 100; i++) begin
            if (rom_rd) begin
                r++;
                if (r == 4) break;
            end
            @(negedge clk);
        end
        chk("abort_reached_col3", r, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rom_rd", rom_rd, 0);
        chk("abort_rom_addr", rom_addr, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        rst   = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || rom_rd) quiet = 1'b0;
        end
        chk("abort_quiet", quiet, 1);
        glyph(8'h21, -1, 0, 1'b0, 8'h00, 1'b0);

        for (int n = 0; n < 10; n++) begin
            glyph(8'($urandom_range(0, 255)), $urandom_range(0, NB),
                  $urandom_range(0, 4), 1'b0, 8'h00, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/font_glyph_seq.md
Name: font_glyph_seq

Overview:
- Sequences column reads from the 6x8 font ROM (1024 x 8, 10-bit address, registered output with rd enable) for the LCD text path.
- Accepts one character code per valid/ready handshake, maps it to a glyph index and issues one ROM read per column.
- Streams the returned column bytes to the LCD write engine over a valid/ready interface with backpressure, marking the last column.

Parameters:
- GLYPH_W, 6, columns (bytes) per glyph.
- FIRST_CHAR, 8'h20, character code mapped to glyph index 0.
- NUM_GLYPHS, 96, glyphs stored in the ROM; NUM_GLYPHS*GLYPH_W must be <= 1024.
- BAD_GLYPH, 31, glyph index substituted for out-of-range codes ('?').
- ADDR_W, 10, ROM address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  character code offered.
- in_ready  out  1  block can accept a code.
- in_char  in  8  character code.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  8  ROM read data.
- out_valid  out  1  column byte available.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  column byte, bit 0 = top pixel row.
- out_last  out  1  marks the final byte of the glyph.
- busy  out  1  glyph in progress (state != IDLE).

Behaviour:
- Reset, checked before any other update:
  - state=IDLE, col=0.
  - rom_rd=0, rom_addr=0, out_valid=0, out_data=0, out_last=0.
  - in_ready=0 while rst is high.
- A reset during a glyph aborts it; no further bytes are emitted.
- in_ready = (state==IDLE) && !rst.
- Index mapping: idx = in_char - FIRST_CHAR when FIRST_CHAR <= in_char < FIRST_CHAR+NUM_GLYPHS, otherwise BAD_GLYPH. idx is registered on acceptance.
- Address: rom_addr = idx*GLYPH_W + col, computed at ADDR_W bits with no wrap (guaranteed by the parameter rule).
- FSM, registered outputs:
  - IDLE: on in_valid&&in_ready (edge T), latch idx, col=0, go to READ.
  - READ (cycle T+1): rom_rd=1, rom_addr valid; go to CAPT.
  - CAPT: rom_rd=0. At the rising edge ending CAPT, out_data<=rom_data, out_valid<=1, out_last<=(col==last column); go to OUT. This timing is valid for both negedge- and posedge-registered ROM outputs.
  - OUT: hold out_data, out_valid and out_last stable until out_ready.
    - On out_valid&&out_ready, if not the last column: col++, out_valid<=0, go to READ.
    - On the last column: out_valid<=0, out_last<=0, go to IDLE.
- Latency: the first byte is valid 3 cycles after acceptance (cycle T+3). Each subsequent byte takes 3 cycles with out_ready held high. The next character can be accepted the cycle after the last byte is handshaken.
- out_ready is ignored whenever out_valid=0. in_valid is ignored outside IDLE, and in_char is not sampled then.
- rom_rd is asserted exactly once per column, never during reset.

Optional Feature:
- Macro FONT_SPACING_EN.
- When defined: after column GLYPH_W-1, one extra byte 8'h00 is emitted with no ROM read (OUT is entered directly from the column handshake). out_last moves to this spacer byte, giving GLYPH_W+1 bytes per glyph.
- When undefined: exactly GLYPH_W bytes per glyph, and out_last is on column GLYPH_W-1.

Decomposition:
- Package font_pkg:
  - GLYPH_W, FIRST_CHAR, NUM_GLYPHS, BAD_GLYPH, ADDR_W defaults.
  - State enum {IDLE, READ, CAPT, OUT}.
  - Column counter width typedef.
- One sub-module, font_addr_gen: range check, idx mapping and idx*GLYPH_W+col address arithmetic.
- The FSM and output registers stay in font_glyph_seq.

Test Plan:
- Send 0x41 ('A'), out_ready=1 → idx 33; rom_addr 198..203, one rom_rd pulse each; 6 bytes equal to ROM contents; out_last only on the 6th; first out_valid 3 cycles after acceptance.
- Send 0x10 and 0x80 (out of range) → addresses 186..191 (BAD_GLYPH) for both.
- Send 0x20 with out_ready low for 5 cycles at column 2 → out_data and out_last stable; no new rom_rd; resumes with column 3 at address 3.
- Offer 0x30 and 0x31 back-to-back with in_valid held → in_ready low during 0x30; 0x31 accepted the cycle after 0x30's out_last handshake; addresses 96..101 then 102..107.
- Assert rst during CAPT of column 3 → the next cycle has all outputs 0 and state IDLE; no further bytes; a new char afterwards is sequenced normally.
- With FONT_SPACING_EN, send 0x41 → 7 bytes, 7th = 8'h00 with out_last=1; 6 rom_rd pulses only.
